// File: rtl/dest_reg_file.sv
// dest_reg_file: 16 x 32-bit accumulator file with four write ports, four
// raw and four processed read ports, and one processed copy port.
// Bias add (set) and ReLU (act) update every entry in a single cycle.
// Ports:
//   clk, rst (synchronous, active low)
//   index_in0..3 / data_in0..3 / w_en0..3 : write address, data, strobe
//   r_raw_en0..3 -> data_out_raw0..3       : raw 32-bit reads, 1-cycle latency
//   r_en0..3     -> data_out0..3           : processed 16-bit reads, 1-cycle latency
//   bias, set, act                         : sign-magnitude bias add, ReLU
//   r_en, index_in -> data_out             : processed copy read, 1-cycle latency
// Macro DEST_REG_SAT_EN: processed reads saturate to signed 16 bits;
// when undefined they truncate to the low 16 bits.
module dest_reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  index_in0,
    input  logic [3:0]  index_in1,
    input  logic [3:0]  index_in2,
    input  logic [3:0]  index_in3,
    input  logic [31:0] data_in0,
    input  logic [31:0] data_in1,
    input  logic [31:0] data_in2,
    input  logic [31:0] data_in3,
    input  logic        w_en0,
    input  logic        w_en1,
    input  logic        w_en2,
    input  logic        w_en3,
    input  logic        r_raw_en0,
    input  logic        r_raw_en1,
    input  logic        r_raw_en2,
    input  logic        r_raw_en3,
    output logic [31:0] data_out_raw0,
    output logic [31:0] data_out_raw1,
    output logic [31:0] data_out_raw2,
    output logic [31:0] data_out_raw3,
    input  logic        r_en0,
    input  logic        r_en1,
    input  logic        r_en2,
    input  logic        r_en3,
    output logic [15:0] data_out0,
    output logic [15:0] data_out1,
    output logic [15:0] data_out2,
    output logic [15:0] data_out3,
    input  logic [15:0] bias,
    input  logic        set,
    input  logic        act,
    input  logic        r_en,
    input  logic [3:0]  index_in,
    output logic [15:0] data_out
);
    logic [31:0] mem [16];
    logic [3:0]  idx [4];
    logic [31:0] din [4];
    logic [3:0]  wen, rraw, rproc;
    logic [31:0] raw_q [4];
    logic [15:0] proc_q [4];
    logic [15:0] copy_q;
    logic [31:0] bias_ext;

    assign idx[0] = index_in0;
    assign idx[1] = index_in1;
    assign idx[2] = index_in2;
    assign idx[3] = index_in3;
    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;
    assign wen   = {w_en3, w_en2, w_en1, w_en0};
    assign rraw  = {r_raw_en3, r_raw_en2, r_raw_en1, r_raw_en0};
    assign rproc = {r_en3, r_en2, r_en1, r_en0};

    assign data_out_raw0 = raw_q[0];
    assign data_out_raw1 = raw_q[1];
    assign data_out_raw2 = raw_q[2];
    assign data_out_raw3 = raw_q[3];
    assign data_out0 = proc_q[0];
    assign data_out1 = proc_q[1];
    assign data_out2 = proc_q[2];
    assign data_out3 = proc_q[3];
    assign data_out  = copy_q;

    // sign-magnitude to two's complement
    assign bias_ext = bias[15] ? -{17'd0, bias[14:0]} : {17'd0, bias[14:0]};

`ifdef DEST_REG_SAT_EN
    function automatic logic [15:0] proc(input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        return (s > 32'sd32767) ? 16'h7fff : (s < -32'sd32768) ? 16'h8000 : x[15:0];
    endfunction
`else
    function automatic logic [15:0] proc(input logic [31:0] x);
        return x[15:0];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            for (int p = 0; p < 4; p++) begin
                raw_q[p]  <= '0;
                proc_q[p] <= '0;
            end
            copy_q <= '0;
        end else begin
            // reads sample the pre-update array, so they see old values
            for (int p = 0; p < 4; p++) begin
                if (rraw[p]) raw_q[p] <= mem[idx[p]];
                if (rproc[p]) proc_q[p] <= proc(mem[idx[p]]);
            end
            if (r_en) copy_q <= proc(mem[index_in]);
            if (set) begin
                for (int i = 0; i < 16; i++) mem[i] <= mem[i] + bias_ext;
            end else if (act) begin
                for (int i = 0; i < 16; i++) mem[i] <= mem[i][31] ? '0 : mem[i];
            end else begin
                // descending order: the lowest port's assignment lands last and wins
                for (int p = 3; p >= 0; p--) if (wen[p]) mem[idx[p]] <= din[p];
            end
        end
    end
endmodule

// File: tb/tb_dest_reg_file.sv
// tb_dest_reg_file: directed self-checking bench for dest_reg_file.
module tb_dest_reg_file;
    logic        clk = 0;
    logic        rst;
    logic [3:0]  index_in0, index_in1, index_in2, index_in3, index_in;
    logic [31:0] data_in0, data_in1, data_in2, data_in3;
    logic        w_en0, w_en1, w_en2, w_en3;
    logic        r_raw_en0, r_raw_en1, r_raw_en2, r_raw_en3;
    logic        r_en0, r_en1, r_en2, r_en3, r_en;
    logic [31:0] data_out_raw0, data_out_raw1, data_out_raw2, data_out_raw3;
    logic [15:0] data_out0, data_out1, data_out2, data_out3, data_out;
    logic [15:0] bias;
    logic        set, act;
    int total = 0;
    int bad = 0;

    dest_reg_file dut (
        .clk(clk), .rst(rst),
        .index_in0(index_in0), .index_in1(index_in1), .index_in2(index_in2), .index_in3(index_in3),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .w_en0(w_en0), .w_en1(w_en1), .w_en2(w_en2), .w_en3(w_en3),
        .r_raw_en0(r_raw_en0), .r_raw_en1(r_raw_en1), .r_raw_en2(r_raw_en2), .r_raw_en3(r_raw_en3),
        .data_out_raw0(data_out_raw0), .data_out_raw1(data_out_raw1),
        .data_out_raw2(data_out_raw2), .data_out_raw3(data_out_raw3),
        .r_en0(r_en0), .r_en1(r_en1), .r_en2(r_en2), .r_en3(r_en3),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .bias(bias), .set(set), .act(act),
        .r_en(r_en), .index_in(index_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {w_en0, w_en1, w_en2, w_en3} = '0;
        {r_raw_en0, r_raw_en1, r_raw_en2, r_raw_en3} = '0;
        {r_en0, r_en1, r_en2, r_en3, r_en} = '0;
        set = 0;
        act = 0;
    endtask

    task automatic wr0(input logic [3:0] a, input logic [31:0] d);
        w_en0 = 1; index_in0 = a; data_in0 = d;
        tick();
        idle();
    endtask

    task automatic raw0(input logic [3:0] a);
        r_raw_en0 = 1; index_in0 = a;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        bias = 0;
        {index_in0, index_in1, index_in2, index_in3, index_in} = '0;
        {data_in0, data_in1, data_in2, data_in3} = '0;
        tick();
        rst = 1;
        // populate, then reset must clear entries and outputs
        wr0(5, 32'h0000_00ab);
        r_raw_en0 = 1; index_in0 = 5; r_en = 1; index_in = 5; r_en0 = 1;
        tick();
        idle();
        chk("pre_rst_raw0", data_out_raw0, 32'h0000_00ab);
        chk("pre_rst_copy", {16'd0, data_out}, 32'h0000_00ab);
        rst = 0; w_en0 = 1; index_in0 = 5; data_in0 = 32'hcd; r_raw_en0 = 1;
        tick();
        idle();
        chk("rst_raw0", data_out_raw0, 0);
        chk("rst_out0", {16'd0, data_out0}, 0);
        chk("rst_copy", {16'd0, data_out}, 0);
        rst = 1;
        raw0(5);
        chk("rst_cleared_e5", data_out_raw0, 0);
        // hold when strobe low
        wr0(5, 32'h77);
        index_in0 = 5;
        tick();
        chk("raw_hold", data_out_raw0, 0);
        // write then read
        wr0(1, 32'h12);
        raw0(1);
        chk("wr_raw_e1", data_out_raw0, 32'h12);
        r_en = 1; index_in = 1; r_en0 = 1; index_in0 = 1;
        tick();
        idle();
        chk("wr_copy_e1", {16'd0, data_out}, 32'h12);
        chk("wr_out0_e1", {16'd0, data_out0}, 32'h12);
        // read during write returns old value
        w_en0 = 1; index_in0 = 1; data_in0 = 32'h55; r_raw_en1 = 1; index_in1 = 1;
        tick();
        idle();
        chk("rdw_old", data_out_raw1, 32'h12);
        raw0(1);
        chk("rdw_new", data_out_raw0, 32'h55);
        wr0(1, 32'h12);
        // bias add, negative then positive; read during set sees old value
        set = 1; bias = 16'h8001; r_raw_en2 = 1; index_in2 = 1;
        tick();
        idle();
        chk("set_rd_old", data_out_raw2, 32'h12);
        raw0(1);
        chk("set_neg", data_out_raw0, 32'h11);
        set = 1; bias = 16'h0003;
        tick();
        idle();
        raw0(1);
        chk("set_pos", data_out_raw0, 32'h14);
        // ReLU
        w_en0 = 1; index_in0 = 2; data_in0 = 32'hffff_fff0;
        w_en1 = 1; index_in1 = 3; data_in1 = 32'h5;
        tick();
        idle();
        act = 1;
        tick();
        idle();
        r_raw_en0 = 1; index_in0 = 2; r_raw_en3 = 1; index_in3 = 3;
        tick();
        idle();
        chk("act_neg", data_out_raw0, 0);
        chk("act_pos", data_out_raw3, 32'h5);
        // set and act together: set only; port write in that cycle dropped
        wr0(7, 32'h10);
        set = 1; act = 1; bias = 16'h8005; w_en0 = 1; index_in0 = 7; data_in0 = 32'h99;
        tick();
        idle();
        r_raw_en0 = 1; index_in0 = 2; r_raw_en1 = 1; index_in1 = 7;
        tick();
        idle();
        chk("setact_e2", data_out_raw0, 32'hffff_fffb);
        chk("setact_e7", data_out_raw1, 32'h0000_000b);
        act = 1; w_en0 = 1; index_in0 = 7; data_in0 = 32'h99;
        tick();
        idle();
        raw0(7);
        chk("act_drop_wr", data_out_raw0, 32'h0000_000b);
        // processed reads: saturation vs truncation
        w_en0 = 1; index_in0 = 4; data_in0 = 32'h0001_2345;
        w_en1 = 1; index_in1 = 8; data_in1 = 32'hffff_0000;
        tick();
        idle();
        r_en = 1; index_in = 4; r_en2 = 1; index_in2 = 4; r_en3 = 1; index_in3 = 8;
        tick();
        idle();
`ifdef DEST_REG_SAT_EN
        chk("proc_pos", {16'd0, data_out}, 32'h7fff);
        chk("proc_pos2", {16'd0, data_out2}, 32'h7fff);
        chk("proc_neg3", {16'd0, data_out3}, 32'h8000);
`else
        chk("proc_pos", {16'd0, data_out}, 32'h2345);
        chk("proc_pos2", {16'd0, data_out2}, 32'h2345);
        chk("proc_neg3", {16'd0, data_out3}, 32'h0000);
`endif
        // processed hold
        index_in = 0;
        tick();
        chk("proc_hold", {16'd0, data_out}, (`ifdef DEST_REG_SAT_EN 32'h7fff `else 32'h2345 `endif));
        // four ports write entries 0..3, then stream copy reads
        w_en0 = 1; index_in0 = 0; data_in0 = 1;
        w_en1 = 1; index_in1 = 1; data_in1 = 2;
        w_en2 = 1; index_in2 = 2; data_in2 = 3;
        w_en3 = 1; index_in3 = 3; data_in3 = 4;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            r_en = 1; index_in = 4'(k);
            tick();
            chk($sformatf("stream%0d", k), {16'd0, data_out}, 32'(k + 1));
        end
        idle();
        r_en1 = 1; index_in1 = 3;
        tick();
        idle();
        chk("out1_e3", {16'd0, data_out1}, 32'h4);
        // same-index collisions: lowest port wins
        w_en0 = 1; index_in0 = 6; data_in0 = 7;
        w_en1 = 1; index_in1 = 6; data_in1 = 9;
        w_en2 = 1; index_in2 = 9; data_in2 = 32'ha;
        w_en3 = 1; index_in3 = 9; data_in3 = 32'hb;
        tick();
        idle();
        r_raw_en0 = 1; index_in0 = 6; r_raw_en2 = 1; index_in2 = 9;
        tick();
        idle();
        chk("coll_e6", data_out_raw0, 32'h7);
        chk("coll_e9", data_out_raw2, 32'ha);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
